// File: rtl/stage2_post_adder_if.sv
// rtl/stage2_post_adder_if.sv - operand/result bundle for the M/P post-adder stage
// Optional PATTERNDETECT signal exists only when PATTERN_DETECT_EN is defined.
interface stage2_post_adder_if;
  logic        CEM;
  logic        CECARRYIN;
  logic        CEOPMODE;
  logic        CEP;
  logic [7:0]  OPMODE;
  logic        CARRYIN;
  logic [35:0] out_Multiplier;
  logic [47:0] concatenated;
  logic [47:0] outC;
  logic [47:0] PCIN;
  logic        in_valid;
  logic [35:0] M;
  logic [47:0] P;
  logic [47:0] PCOUT;
  logic        CARRYOUT;
  logic        CARRYOUTF;
  logic        out_valid;
`ifdef PATTERN_DETECT_EN
  logic        PATTERNDETECT;
`endif

  modport master (
    output CEM, CECARRYIN, CEOPMODE, CEP, OPMODE, CARRYIN,
    output out_Multiplier, concatenated, outC, PCIN, in_valid,
`ifdef PATTERN_DETECT_EN
    input  PATTERNDETECT,
`endif
    input  M, P, PCOUT, CARRYOUT, CARRYOUTF, out_valid
  );

  modport slave (
    input  CEM, CECARRYIN, CEOPMODE, CEP, OPMODE, CARRYIN,
    input  out_Multiplier, concatenated, outC, PCIN, in_valid,
`ifdef PATTERN_DETECT_EN
    output PATTERNDETECT,
`endif
    output M, P, PCOUT, CARRYOUT, CARRYOUTF, out_valid
  );
endinterface

// File: rtl/stage2_post_adder.sv
// rtl/stage2_post_adder.sv - DSP48A1 M-stage registers, X/Z muxes, 48-bit post-add/sub and P register
// Optional pattern detector on the post-adder result is enabled by defining PATTERN_DETECT_EN.
module stage2_post_adder #(
  parameter bit MREG       = 1'b1,
  parameter bit CARRYINREG = 1'b1,
  parameter bit OPMODEREG  = 1'b1,
  parameter bit PREG       = 1'b1,
`ifdef PATTERN_DETECT_EN
  parameter logic [47:0] PATTERN = 48'h0,
  parameter logic [47:0] MASK    = 48'h0,
`endif
  parameter     CARRYINSEL = "OPMODE5"
) (
  input  logic                    clk,
  input  logic                    RST_N,
  stage2_post_adder_if.slave      bus
);

  // Anything other than "CARRYIN" falls back to OPMODE[5].
  localparam bit CIN_EXT = (CARRYINSEL == "CARRYIN");

  logic [35:0] m_q;
  logic        cin_q;
  logic [4:0]  op_q;
  logic        vm_q;
  logic [47:0] p_q;
  logic        co_q;
  logic        vp_q;

  logic        cin_raw;
  logic [4:0]  op_raw;
  logic [35:0] m_s;
  logic        cin_s;
  logic [4:0]  op_s;
  logic        vm_s;
  logic [47:0] p_fb;
  logic [47:0] x_op;
  logic [47:0] z_op;
  logic [48:0] addend;
  logic [48:0] r;
  logic        unused_opmode;

  assign unused_opmode = ^{bus.OPMODE[6], bus.OPMODE[4]};

  // op_raw packs {OPMODE[7], OPMODE[3:0]}; OPMODE[5] travels through the carry-in register.
  assign cin_raw = CIN_EXT ? bus.CARRYIN : bus.OPMODE[5];
  assign op_raw  = {bus.OPMODE[7], bus.OPMODE[3:0]};

  assign m_s   = MREG       ? m_q   : bus.out_Multiplier;
  assign cin_s = CARRYINREG ? cin_q : cin_raw;
  assign op_s  = OPMODEREG  ? op_q  : op_raw;
  assign vm_s  = MREG       ? vm_q  : bus.in_valid;

  // Without a P register, feedback would be a combinational loop, so it reads as zero.
  assign p_fb = PREG ? p_q : 48'h0;

  always_comb begin
    x_op = 48'h0;
    case (op_s[1:0])
      2'd0: x_op = 48'h0;
      2'd1: x_op = {12'h0, m_s};
      2'd2: x_op = p_fb;
      2'd3: x_op = bus.concatenated;
    endcase
  end

  always_comb begin
    z_op = 48'h0;
    case (op_s[3:2])
      2'd0: z_op = 48'h0;
      2'd1: z_op = bus.PCIN;
      2'd2: z_op = p_fb;
      2'd3: z_op = bus.outC;
    endcase
  end

  assign addend = {1'b0, x_op} + {48'h0, cin_s};
  assign r      = op_s[4] ? ({1'b0, z_op} - addend) : ({1'b0, z_op} + addend);

`ifdef PATTERN_DETECT_EN
  logic pd_c;
  logic pd_q;
  assign pd_c = (((r[47:0] ^ PATTERN) & ~MASK) == 48'h0);
`endif

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      m_q   <= '0;
      vm_q  <= 1'b0;
      cin_q <= 1'b0;
      op_q  <= '0;
      p_q   <= '0;
      co_q  <= 1'b0;
      vp_q  <= 1'b0;
`ifdef PATTERN_DETECT_EN
      pd_q  <= 1'b0;
`endif
    end else begin
      if (bus.CEM) begin
        m_q  <= bus.out_Multiplier;
        vm_q <= bus.in_valid;
      end
      if (bus.CECARRYIN) cin_q <= cin_raw;
      if (bus.CEOPMODE)  op_q  <= op_raw;
      if (bus.CEP) begin
        p_q  <= r[47:0];
        co_q <= r[48];
        vp_q <= vm_s;
`ifdef PATTERN_DETECT_EN
        pd_q <= pd_c;
`endif
      end
    end
  end

  // Bypassed stages are combinational, so outputs are forced low during reset as well.
  assign bus.M         = RST_N ? m_s : '0;
  assign bus.P         = RST_N ? (PREG ? p_q  : r[47:0]) : '0;
  assign bus.CARRYOUT  = RST_N ? (PREG ? co_q : r[48])   : 1'b0;
  assign bus.out_valid = RST_N ? (PREG ? vp_q : vm_s)    : 1'b0;
  assign bus.PCOUT     = bus.P;
  assign bus.CARRYOUTF = bus.CARRYOUT;
`ifdef PATTERN_DETECT_EN
  assign bus.PATTERNDETECT = RST_N ? (PREG ? pd_q : pd_c) : 1'b0;
`endif

endmodule

// File: tb/tb_stage2_post_adder.sv
// tb/tb_stage2_post_adder.sv - self-checking bench for stage2_post_adder with an in-bench reference model
// PATTERN_DETECT_EN adds pattern detector checks.
module tb_stage2_post_adder;
  logic clk = 1'b0;
  logic rst_n;
  logic cmp_en;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stage2_post_adder_if bus ();
  stage2_post_adder_if bus2 ();

  stage2_post_adder dut (
    .clk   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  stage2_post_adder #(
    .PREG       (1'b0),
`ifdef PATTERN_DETECT_EN
    .PATTERN    (48'd7),
    .MASK       (48'h0),
`endif
    .CARRYINSEL ("CARRYIN")
  ) dut2 (
    .clk   (clk),
    .RST_N (rst_n),
    .bus   (bus2)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of the post-adder as an ordinary 64-bit sum/difference; bit 48 is the carry or borrow.
  function automatic logic [48:0] post_add(input logic sub, input logic [47:0] z,
                                           input logic [47:0] x, input logic cin);
    longint unsigned zz, xx, rr;
    zz = {16'h0, z};
    xx = {16'h0, x};
    rr = sub ? (zz - xx - {63'h0, cin}) : (zz + xx + {63'h0, cin});
    return rr[48:0];
  endfunction

  // Reference model for dut (all registers on, CARRYINSEL = OPMODE5, PATTERN = MASK = 0).
  logic [35:0] mdl_m;
  logic        mdl_cin;
  logic [7:0]  mdl_op;
  logic        mdl_vm;
  logic [47:0] mdl_p;
  logic        mdl_co;
  logic        mdl_vp;
  logic        mdl_pd;
  logic [47:0] mdl_operand [4];
  logic [48:0] mdl_r;

  always_comb begin
    mdl_operand[0] = 48'h0;
    mdl_operand[1] = {12'h0, mdl_m};
    mdl_operand[2] = mdl_p;
    mdl_operand[3] = bus.concatenated;
    mdl_r = post_add(mdl_op[7],
                     (mdl_op[3:2] == 2'd0) ? 48'h0 :
                     (mdl_op[3:2] == 2'd1) ? bus.PCIN :
                     (mdl_op[3:2] == 2'd2) ? mdl_p : bus.outC,
                     mdl_operand[mdl_op[1:0]], mdl_cin);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_m <= '0; mdl_cin <= 1'b0; mdl_op <= '0; mdl_vm <= 1'b0;
      mdl_p <= '0; mdl_co <= 1'b0; mdl_vp <= 1'b0; mdl_pd <= 1'b0;
    end else begin
      if (bus.CEM) begin
        mdl_m  <= bus.out_Multiplier;
        mdl_vm <= bus.in_valid;
      end
      if (bus.CECARRYIN) mdl_cin <= bus.OPMODE[5];
      if (bus.CEOPMODE)  mdl_op  <= bus.OPMODE;
      if (bus.CEP) begin
        mdl_p  <= mdl_r[47:0];
        mdl_co <= mdl_r[48];
        mdl_vp <= mdl_vm;
        mdl_pd <= (mdl_r[47:0] == 48'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_P",         bus.P,                 mdl_p);
      check("cmp_PCOUT",     bus.PCOUT,             mdl_p);
      check("cmp_M",         {12'h0, bus.M},        {12'h0, mdl_m});
      check("cmp_CARRYOUT",  {47'h0, bus.CARRYOUT}, {47'h0, mdl_co});
      check("cmp_CARRYOUTF", {47'h0, bus.CARRYOUTF},{47'h0, mdl_co});
      check("cmp_out_valid", {47'h0, bus.out_valid},{47'h0, mdl_vp});
`ifdef PATTERN_DETECT_EN
      check("cmp_PATTERNDETECT", {47'h0, bus.PATTERNDETECT}, {47'h0, mdl_pd});
`endif
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    cmp_en = 1'b0;
    bus.CEM = 1'b0; bus.CECARRYIN = 1'b0; bus.CEOPMODE = 1'b0; bus.CEP = 1'b0;
    bus.OPMODE = 8'h00; bus.CARRYIN = 1'b0; bus.out_Multiplier = '0;
    bus.concatenated = '0; bus.outC = '0; bus.PCIN = '0; bus.in_valid = 1'b0;
    bus2.CEM = 1'b1; bus2.CECARRYIN = 1'b1; bus2.CEOPMODE = 1'b1; bus2.CEP = 1'b1;
    bus2.OPMODE = 8'h00; bus2.CARRYIN = 1'b0; bus2.out_Multiplier = '0;
    bus2.concatenated = '0; bus2.outC = '0; bus2.PCIN = '0; bus2.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #2 cmp_en = 1'b1;
    @(negedge clk);
    check("reset_P",         bus.P, 48'h0);
    check("reset_out_valid", {47'h0, bus.out_valid}, 48'h0);
    #1 rst_n = 1'b1;

    // Product passes through M then P: M after one edge, P and out_valid after two.
    bus.CEM = 1'b1; bus.CECARRYIN = 1'b1; bus.CEOPMODE = 1'b1; bus.CEP = 1'b1;
    bus.in_valid = 1'b1; bus.out_Multiplier = 36'd6; bus.OPMODE = 8'h01;
    settle(1);
    check("lat_M",         {12'h0, bus.M}, 48'd6);
    check("lat_valid_early", {47'h0, bus.out_valid}, 48'h0);
    settle(1);
    check("lat_P",         bus.P, 48'd6);
    check("lat_valid",     {47'h0, bus.out_valid}, 48'h1);
    check("lat_CARRYOUT",  {47'h0, bus.CARRYOUT}, 48'h0);

    #1 bus.OPMODE = 8'h0D; bus.outC = 48'd100; bus.out_Multiplier = 36'd5;
    settle(2);
    check("add_C_M", bus.P, 48'd105);
    #1 bus.OPMODE = 8'h8D;
    settle(2);
    check("sub_C_M", bus.P, 48'd95);
    #1 bus.out_Multiplier = 36'd101;
    settle(2);
    check("sub_borrow_P",  bus.P, 48'hFFFF_FFFF_FFFF);
    check("sub_borrow_CO", {47'h0, bus.CARRYOUT}, 48'h1);

    #1 bus.OPMODE = 8'h0D; bus.outC = 48'hFFFF_FFFF_FFFF; bus.out_Multiplier = 36'd1;
    settle(2);
    check("wrap_P",  bus.P, 48'h0);
    check("wrap_CO", {47'h0, bus.CARRYOUT}, 48'h1);

    // Accumulate M = 3 into P, starting from P = 0.
    #1 bus.OPMODE = 8'h00; bus.out_Multiplier = 36'd3;
    settle(2);
    check("acc_start", bus.P, 48'h0);
    #1 bus.OPMODE = 8'h09;
    settle(2);
    check("acc_1", bus.P, 48'd3);
    for (int k = 2; k <= 4; k++) begin
      settle(1);
      check("acc_n", bus.P, 48'(3 * k));
    end
    #1 bus.CEP = 1'b0;
    settle(3);
    check("acc_hold_P",     bus.P, 48'd12);
    check("acc_hold_valid", {47'h0, bus.out_valid}, 48'h1);

    // Asynchronous reset between edges discards everything in flight.
    #1 bus.CEP = 1'b1; bus.OPMODE = 8'h01; bus.out_Multiplier = 36'd9;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_P",     bus.P, 48'h0);
    check("arst_M",     {12'h0, bus.M}, 48'h0);
    check("arst_CO",    {47'h0, bus.CARRYOUT}, 48'h0);
    check("arst_valid", {47'h0, bus.out_valid}, 48'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    settle(1);
    check("arst_rel_P",     bus.P, 48'h0);
    check("arst_rel_valid", {47'h0, bus.out_valid}, 48'h0);
    check("arst_rel_M",     {12'h0, bus.M}, 48'd9);
    settle(1);
    check("arst_new_P",     bus.P, 48'd9);
    check("arst_new_valid", {47'h0, bus.out_valid}, 48'h1);

    // PREG = 0 instance: feedback selects zero, result is combinational from M stage.
    #1 bus2.OPMODE = 8'h0A; bus2.out_Multiplier = 36'd7; bus2.in_valid = 1'b1;
    settle(1);
    check("nop_fb_P",     bus2.P, 48'h0);
    check("nop_valid",    {47'h0, bus2.out_valid}, 48'h1);
    #1 bus2.OPMODE = 8'h09;
    settle(1);
    check("nop_acc_P",    bus2.P, 48'd7);
    check("nop_acc_PCOUT", bus2.PCOUT, 48'd7);
`ifdef PATTERN_DETECT_EN
    check("nop_pattern",  {47'h0, bus2.PATTERNDETECT}, 48'h1);
`endif
    #1 bus2.CARRYIN = 1'b1;
    settle(1);
    check("nop_cin_port", bus2.P, 48'd8);
`ifdef PATTERN_DETECT_EN
    check("nop_pattern_miss", {47'h0, bus2.PATTERNDETECT}, 48'h0);
`endif

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
